// File: rtl/road_pkg.sv
// Shared definitions for the scrolling road: pixel classification codes,
// default colours, road sides and the lane-centre arithmetic.
package road_pkg;

  typedef enum logic [2:0] {
    PIX_TRANSPARENT,
    PIX_ROAD,
    PIX_LINE,
    PIX_LEFT_EDGE,
    PIX_RIGHT_EDGE
  } pix_code_t;

  localparam logic [7:0] ROAD_COLOR_DEF = 8'b011_011_01;
  localparam logic [7:0] LINE_COLOR_DEF = 8'hFF;
  localparam logic [7:0] EDGE_COLOR_DEF = 8'b000_000_11;

  localparam logic [1:0] SIDE_NONE  = 2'b00;
  localparam logic [1:0] SIDE_RIGHT = 2'b01;
  localparam logic [1:0] SIDE_LEFT  = 2'b10;

  // Pixel x of the middle of lane idx, given the row's left block position.
  function automatic logic [10:0] lane_center_px(input int left, input int idx,
                                                 input int edge_w, input int lw,
                                                 input int block_w);
    return 11'((left + edge_w + idx * (lw + 2)) * block_w + lw * block_w / 2);
  endfunction

endpackage

// File: rtl/road_pixel_decode.sv
// Classifies one pixel by its block offset from the row's left road edge
// and maps the class to a colour, draw flag and road side.
module road_pixel_decode import road_pkg::*; #(
  parameter int         ROAD_W     = 26,
  parameter int         EDGE_W     = 2,
  parameter int         LANES      = 2,
  parameter int         LW         = 10,
  parameter logic [7:0] ROAD_COLOR = ROAD_COLOR_DEF,
  parameter logic [7:0] LINE_COLOR = LINE_COLOR_DEF,
  parameter logic [7:0] EDGE_COLOR = EDGE_COLOR_DEF
) (
  input  logic               in_rows,
  input  logic signed [12:0] offset,
  input  logic               dash,
  output logic [7:0]         rgb,
  output logic               draw,
  output logic [1:0]         road_edge
);

  localparam logic signed [12:0] RW = 13'(ROAD_W);
  localparam logic signed [12:0] EW = 13'(EDGE_W);

  pix_code_t          code;
  logic signed [12:0] inner;

  // Offset measured from the first block inside the left edge.
  assign inner = offset - EW;

  // Region decode: off-road sides, edges, then dividers inside the road.
  always_comb begin
    code      = PIX_TRANSPARENT;
    road_edge = SIDE_NONE;
    if (in_rows) begin
      if (offset < 13'sd0)
        road_edge = SIDE_LEFT;
      else if (offset >= RW)
        road_edge = SIDE_RIGHT;
      else if (offset < EW) begin
        code      = PIX_LEFT_EDGE;
        road_edge = SIDE_LEFT;
      end else if (offset >= RW - EW) begin
        code      = PIX_RIGHT_EDGE;
        road_edge = SIDE_RIGHT;
      end else begin
        code = PIX_ROAD;
        // Divider k is two blocks wide and directly follows lane k.
        for (int k = 0; k < LANES - 1; k++)
          if (dash && inner >= 13'(k * (LW + 2) + LW) && inner < 13'(k * (LW + 2) + LW + 2))
            code = PIX_LINE;
      end
    end
  end

  // Colour lookup for the pixel class.
  always_comb begin
    rgb = '0;
    case (code)
      PIX_ROAD:                      rgb = ROAD_COLOR;
      PIX_LINE:                      rgb = LINE_COLOR;
      PIX_LEFT_EDGE, PIX_RIGHT_EDGE: rgb = EDGE_COLOR;
      default:                       rgb = '0;
    endcase
  end

  assign draw = (code != PIX_TRANSPARENT);

endmodule

// File: rtl/road_scroll_mem.sv
// Per-row road geometry store that scrolls down by Yspeed>>2 rows per frame,
// bending at the top row on curve commands, plus registered pixel lookup.
module road_scroll_mem import road_pkg::*; #(
  parameter int         BLOCK_W     = 8,
  parameter int         ROWS        = 480,
  parameter int         ROAD_W      = 26,
  parameter int         EDGE_W      = 2,
  parameter int         LANES       = 2,
  parameter int         DASH_PERIOD = 48,
  parameter int         INIT_X      = 18,
  parameter int         MIN_X       = 2,
  parameter int         MAX_X       = 52,
  parameter int         REF_ROW     = ROWS - 1,
  parameter logic [7:0] ROAD_COLOR  = ROAD_COLOR_DEF,
  parameter logic [7:0] LINE_COLOR  = LINE_COLOR_DEF,
  parameter logic [7:0] EDGE_COLOR  = EDGE_COLOR_DEF
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic [4:0]             Yspeed,
  input  logic [1:0]             new_x_offset,
  input  logic                   pause,
  input  logic [10:0]            x_position,
  input  logic [10:0]            Y_position,
  output logic [7:0]             ROAD_RGB,
  output logic                   Draw_request,
  output logic [1:0]             Road_Edge,
  output logic                   need_new_line,
  output logic                   scroll_done,
  output logic [LANES-1:0][10:0] lane_center
);

  localparam int LW  = (ROAD_W - 2 * EDGE_W - 2 * (LANES - 1)) / LANES;
  localparam int BSH = $clog2(BLOCK_W);
  localparam int YW  = $clog2(ROWS);
  localparam int DCW = $clog2(DASH_PERIOD);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]         state;
  logic [4:0]         n_next, n_lat, done_cnt;
  logic               shift_en;
  logic [6:0]         left [ROWS];
  logic [ROWS-1:0]    dash;
  logic [DCW-1:0]     dash_cnt;
  logic [6:0]         next_left;

  logic               in_rows;
  logic [YW-1:0]      y_idx;
  logic [6:0]         row_left;
  logic               row_dash;
  logic [10:0]        block;
  logic signed [12:0] offset;
  logic [7:0]         rgb_d;
  logic               draw_d;
  logic [1:0]         edge_d;

  assign n_next        = Yspeed >> 2;
  // A frame start always wins over a pending shift in the same cycle.
  assign shift_en      = (state == SHIFT) && !startOfFrame;
  assign need_new_line = (state == SHIFT);
  assign scroll_done   = (state == DONE);

  // Frame sequencer; a new frame start restarts the count from any state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      n_lat    <= '0;
      done_cnt <= '0;
    end else if (startOfFrame) begin
      n_lat    <= n_next;
      done_cnt <= '0;
      state    <= (n_next == 5'd0 || pause) ? DONE : SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          done_cnt <= done_cnt + 5'd1;
          if (done_cnt + 5'd1 == n_lat) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // New top-row position: one block step per shift, clamped to the limits.
  always_comb begin
    next_left = left[0];
    case (new_x_offset)
      2'b01:   next_left = (left[0] < 7'(MAX_X)) ? left[0] + 7'd1 : 7'(MAX_X);
      2'b11:   next_left = (left[0] > 7'(MIN_X)) ? left[0] - 7'd1 : 7'(MIN_X);
      default: next_left = left[0];
    endcase
  end

  // Row store: every shift pushes rows down one and generates a new row 0.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int r = 0; r < ROWS; r++) begin
        left[r] <= 7'(INIT_X);
        dash[r] <= (r % DASH_PERIOD) < DASH_PERIOD / 2;
      end
      dash_cnt <= '0;
    end else if (shift_en) begin
      for (int r = ROWS - 1; r > 0; r--) begin
        left[r] <= left[r-1];
        dash[r] <= dash[r-1];
      end
      left[0]  <= next_left;
      dash[0]  <= dash_cnt < DCW'(DASH_PERIOD / 2);
      dash_cnt <= (dash_cnt == DCW'(DASH_PERIOD - 1)) ? '0 : dash_cnt + 1'b1;
    end
  end

  assign in_rows  = Y_position < 11'(ROWS);
  assign y_idx    = Y_position[YW-1:0];
  assign row_left = in_rows ? left[y_idx] : '0;
  assign row_dash = in_rows & dash[y_idx];
  assign block    = x_position >> BSH;
  assign offset   = $signed({2'b00, block}) - $signed({6'b000000, row_left});

  road_pixel_decode #(
    .ROAD_W     (ROAD_W),
    .EDGE_W     (EDGE_W),
    .LANES      (LANES),
    .LW         (LW),
    .ROAD_COLOR (ROAD_COLOR),
    .LINE_COLOR (LINE_COLOR),
    .EDGE_COLOR (EDGE_COLOR)
  ) u_decode (
    .in_rows   (in_rows),
    .offset    (offset),
    .dash      (row_dash),
    .rgb       (rgb_d),
    .draw      (draw_d),
    .road_edge (edge_d)
  );

  // Pixel outputs, one clock behind the pixel coordinates.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ROAD_RGB     <= '0;
      Draw_request <= 1'b0;
      Road_Edge    <= SIDE_NONE;
    end else begin
      ROAD_RGB     <= rgb_d;
      Draw_request <= draw_d;
      Road_Edge    <= edge_d;
    end
  end

  // Lane centres follow the reference row every clock.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < LANES; i++)
        lane_center[i] <= lane_center_px(INIT_X, i, EDGE_W, LW, BLOCK_W);
    end else begin
      for (int i = 0; i < LANES; i++)
        lane_center[i] <= lane_center_px(int'(left[REF_ROW]), i, EDGE_W, LW, BLOCK_W);
    end
  end

endmodule

// File: tb/tb_road_scroll_mem.sv
// Scoreboard bench for road_scroll_mem: stimulus pushes expected frame and
// pixel responses from a row-queue model; monitors pop and compare.
module tb_road_scroll_mem;

  localparam int ROWS = 480, DP = 48, MIN_X = 2, MAX_X = 52, INIT_X = 18;
  localparam logic [7:0] C_ROAD = 8'h6D, C_LINE = 8'hFF, C_EDGE = 8'h03;

  logic clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0, pause = 1'b0;
  logic [4:0]  Yspeed = '0;
  logic [1:0]  new_x_offset = '0;
  logic [10:0] x_position = '0, Y_position = '0;
  logic [7:0]  ROAD_RGB, rgb3;
  logic        Draw_request, draw3, need_new_line, nnl3, scroll_done, sd3;
  logic [1:0]  Road_Edge, edge3;
  logic [1:0][10:0] lane_center;
  logic [2:0][10:0] lane_center3;

  always #5 clk = ~clk;

  road_scroll_mem dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .Yspeed(Yspeed),
    .new_x_offset(new_x_offset), .pause(pause), .x_position(x_position),
    .Y_position(Y_position), .ROAD_RGB(ROAD_RGB), .Draw_request(Draw_request),
    .Road_Edge(Road_Edge), .need_new_line(need_new_line), .scroll_done(scroll_done),
    .lane_center(lane_center));

  road_scroll_mem #(.LANES(3)) dut3 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .Yspeed(Yspeed),
    .new_x_offset(new_x_offset), .pause(pause), .x_position(x_position),
    .Y_position(Y_position), .ROAD_RGB(rgb3), .Draw_request(draw3),
    .Road_Edge(edge3), .need_new_line(nnl3), .scroll_done(sd3),
    .lane_center(lane_center3));

  typedef struct packed {
    logic [7:0]       rgb;
    logic             draw;
    logic [1:0]       side;
    logic [1:0][10:0] lc;
    logic [2:0][10:0] lc3;
  } pix_exp_t;

  typedef struct packed {
    int nnl;
    int lat;
  } frm_exp_t;

  pix_exp_t pq[$];
  frm_exp_t fq[$];
  int checks = 0, errors = 0;
  int m_left[$];
  bit m_dash[$];
  int m_shifts = 0;
  logic req_v = 1'b0, pix_pend = 1'b0;
  int since_sof = 0, nnl_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the road is a list of rows, newest at the front.
  function automatic void model_reset();
    m_left.delete();
    m_dash.delete();
    for (int r = 0; r < ROWS; r++) begin
      m_left.push_back(INIT_X);
      m_dash.push_back((r % DP) < DP / 2);
    end
    m_shifts = 0;
  endfunction

  function automatic void model_shift(input logic [1:0] xo);
    int nl;
    nl = m_left[0];
    if (xo == 2'b01) nl = (nl + 1 > MAX_X) ? MAX_X : nl + 1;
    else if (xo == 2'b11) nl = (nl - 1 < MIN_X) ? MIN_X : nl - 1;
    m_left.push_front(nl);
    m_left.delete(m_left.size() - 1);
    m_dash.push_front((m_shifts % DP) < DP / 2);
    m_dash.delete(m_dash.size() - 1);
    m_shifts++;
  endfunction

  function automatic int lc_model(input int left, input int i, input int lanes);
    int lw;
    lw = (26 - 4 - 2 * (lanes - 1)) / lanes;
    return (left + 2 + i * (lw + 2)) * 8 + lw * 8 / 2;
  endfunction

  function automatic pix_exp_t pix_model(input int x, input int y);
    pix_exp_t e;
    int off, inner;
    e = '0;
    for (int i = 0; i < 2; i++) e.lc[i]  = 11'(lc_model(m_left[ROWS-1], i, 2));
    for (int i = 0; i < 3; i++) e.lc3[i] = 11'(lc_model(m_left[ROWS-1], i, 3));
    if (y < ROWS) begin
      off = x / 8 - m_left[y];
      if (off < 0) e.side = 2'b10;
      else if (off >= 26) e.side = 2'b01;
      else begin
        e.draw = 1'b1;
        if (off < 2) begin e.rgb = C_EDGE; e.side = 2'b10; end
        else if (off >= 24) begin e.rgb = C_EDGE; e.side = 2'b01; end
        else begin
          inner = off - 2;
          e.rgb = (inner / 12 < 1 && inner % 12 >= 10 && m_dash[y]) ? C_LINE : C_ROAD;
        end
      end
    end
    return e;
  endfunction

  task automatic drain();
    int t;
    t = 0;
    while ((fq.size() != 0 || pq.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d frames %0d pixels pending required 0", fq.size(), pq.size());
      fq.delete();
      pq.delete();
    end
    @(negedge clk);
  endtask

  task automatic pix(input int x, input int y);
    @(negedge clk);
    x_position = 11'(x);
    Y_position = 11'(y);
    req_v = 1'b1;
    pq.push_back(pix_model(x, y));
  endtask

  task automatic pix_end();
    @(negedge clk);
    req_v = 1'b0;
    drain();
  endtask

  task automatic pix_rand(input int n);
    int y, x;
    for (int i = 0; i < n; i++) begin
      y = $urandom_range(0, 520);
      x = ((y < ROWS) ? m_left[y] : m_left[0]) * 8 + $urandom_range(0, 270) - 30;
      if (x < 0) x = 0;
      pix(x, y);
    end
    pix_end();
  endtask

  task automatic frame(input int ys, input logic [1:0] xo, input bit ps);
    int n;
    frm_exp_t f;
    n = ps ? 0 : (ys >> 2);
    @(negedge clk);
    Yspeed = 5'(ys);
    new_x_offset = xo;
    pause = ps;
    startOfFrame = 1'b1;
    f.nnl = n;
    f.lat = n;
    fq.push_back(f);
    for (int i = 0; i < n; i++) model_shift(xo);
    @(negedge clk);
    startOfFrame = 1'b0;
    pause = 1'b0;
    drain();
  endtask

  // Second frame start arrives after k shifts of the first frame.
  task automatic restart(input int ys1, input int k, input int ys2, input logic [1:0] xo);
    frm_exp_t f;
    @(negedge clk);
    Yspeed = 5'(ys1);
    new_x_offset = xo;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    repeat (k) @(negedge clk);
    Yspeed = 5'(ys2);
    startOfFrame = 1'b1;
    f.nnl = k + 1 + (ys2 >> 2);
    f.lat = ys2 >> 2;
    fq.push_back(f);
    for (int i = 0; i < k + (ys2 >> 2); i++) model_shift(xo);
    @(negedge clk);
    startOfFrame = 1'b0;
    drain();
  endtask

  always @(posedge clk) begin
    pix_pend  <= req_v;
    since_sof <= startOfFrame ? 0 : since_sof + 1;
  end

  // Monitor: pops the expected response whenever the DUT presents one.
  always @(negedge clk) begin : mon
    frm_exp_t f;
    pix_exp_t p;
    if (!resetN) nnl_cnt = 0;
    else begin
      if (need_new_line) nnl_cnt++;
      if (scroll_done) begin
        if (fq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_scroll_done: got 1 required 0");
        end else begin
          f = fq.pop_front();
          chk("need_new_line_cycles", nnl_cnt, f.nnl);
          chk("scroll_done_latency", since_sof, f.lat);
        end
        nnl_cnt = 0;
      end
    end
    if (pix_pend) begin
      if (pq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pixel_underflow: got response with empty queue");
      end else begin
        p = pq.pop_front();
        chk("ROAD_RGB", ROAD_RGB, p.rgb);
        chk("Draw_request", Draw_request, p.draw);
        chk("Road_Edge", Road_Edge, p.side);
        chk("lane_center", lane_center, p.lc);
        chk("lane_center3", lane_center3, p.lc3);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_rgb", ROAD_RGB, 0);
    chk("rst_draw", Draw_request, 0);
    chk("rst_edge", Road_Edge, 0);
    chk("rst_nnl", need_new_line, 0);
    chk("rst_done", scroll_done, 0);
    chk("rst_lc0", lane_center[0], 200);
    chk("rst_lc1", lane_center[1], 296);
    chk("rst_lc3_0", lane_center3[0], 184);
    chk("rst_lc3_1", lane_center3[1], 248);
    chk("rst_lc3_2", lane_center3[2], 312);
    resetN = 1'b1;

    pix(144, 479); pix(240, 479); pix(240, 0); pix(100, 479);
    pix(359, 0); pix(360, 0); pix(40, 600); pix(2047, 479);
    pix_end();

    frame(8, 2'b00, 1'b0);
    pix(144, 0); pix(143, 0); pix(144, 2); pix(240, 1); pix_end();

    frame(3, 2'b01, 1'b0);
    frame(28, 2'b01, 1'b1);
    frame(0, 2'b11, 1'b0);
    pix(144, 0); pix_end();

    restart(12, 1, 20, 2'b00);
    pix_rand(6);

    for (int i = 0; i < 6; i++) frame(31, 2'b01, 1'b0);
    pix(52 * 8, 0); pix(51 * 8 + 7, 0); pix(78 * 8 - 1, 0); pix(78 * 8, 0);
    pix(52 * 8, 10); pix_end();
    pix_rand(8);

    for (int i = 0; i < 25; i++) begin
      frame($urandom_range(0, 31), 2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
      pix_rand(6);
    end

    // Reset asserted mid-scroll abandons the frame.
    @(negedge clk);
    x_position = 11'd144;
    Y_position = 11'd0;
    Yspeed = 5'd28;
    new_x_offset = 2'b01;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_nnl", need_new_line, 0);
    chk("midrst_draw", Draw_request, 0);
    chk("midrst_lc0", lane_center[0], 200);
    @(negedge clk);
    resetN = 1'b1;
    repeat (10) @(negedge clk);
    pix(144, 0); pix(240, 0); pix(144, 300); pix_end();
    pix_rand(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
